bitty_seq_ctrl: RTL and testbench

BITTY_SEQ_CTRL -- requirements
Module: bitty_seq_ctrl

---
 rtl/bitty_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_bitty_seq_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_seq_ctrl.sv
// bitty_seq_ctrl: fetch/decode/execute sequencer for the bitty core.
// Fetches one instruction word at pc, either hands it to the execution core
// or resolves it locally as a branch, then advances pc and counts retirements.
// Runs freely while run is high, or one instruction per step pulse.

module bitty_seq_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int INSTR_W   = 16,
   parameter int DATA_W    = 16,
   parameter int FETCH_LAT = 1,
   parameter int TIMEOUT   = 255,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               step_mode,
   input  logic               step,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] core_instr,
   output logic               core_start,
   input  logic               core_done,
   input  logic [DATA_W-1:0]  core_result,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic               fault,
   output logic [CNT_W-1:0]   retired
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      UPDATE,
      HALT
   } state_t;

   localparam int FL_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [FL_W-1:0] FETCH_LAST = FL_W'(FETCH_LAT - 1);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

   state_t              state;
   state_t              state_nxt;
   logic [FL_W-1:0]     fetch_cnt;
   logic [TO_W-1:0]     tmo_cnt;
   logic [DATA_W-1:0]   last_result;

   logic                fetch_last;
   logic                exec_first;
   logic                exec_expire;
   logic                is_halt;
   logic                is_branch;
   logic                br_taken;
   logic [ADDR_W-1:0]   br_target;

   assign imem_addr   = pc;
   assign fetch_last  = (fetch_cnt == FETCH_LAST);
   assign exec_first  = (tmo_cnt == '0);
   assign exec_expire = (tmo_cnt == TO_LAST);
   assign is_halt     = (core_instr == '1);
   assign is_branch   = (core_instr[1:0] == 2'b10);
   assign br_target   = core_instr[ADDR_W+3:4];

   // Branch condition on the signed result of the last executed instruction.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      br_taken = 1'b0;
      case (core_instr[3:2])
         2'b00:   br_taken = (last_result == '0);
         2'b01:   br_taken = !last_result[DATA_W-1] && (last_result != '0);
         2'b10:   br_taken = last_result[DATA_W-1];
         default: br_taken = 1'b0;
      endcase
      br_taken = br_taken && is_branch;
   end

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decision and state-decoded outputs.
   always_comb begin
      state_nxt  = state;
      core_start = 1'b0;
      busy       = 1'b1;
      halted     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if ((!step_mode && run) || (step_mode && step)) state_nxt = FETCH;
         end
         FETCH: begin
            if (fetch_last) state_nxt = DECODE;
         end
         DECODE: begin
            if (is_halt)        state_nxt = HALT;
            else if (is_branch) state_nxt = UPDATE;
            else                state_nxt = EXEC;
         end
         EXEC: begin
            core_start = exec_first;
            // A done arriving with the start pulse is already a valid finish.
            if (core_done)        state_nxt = UPDATE;
            else if (exec_expire) state_nxt = HALT;
         end
         UPDATE: begin
            state_nxt = (!step_mode && run) ? FETCH : IDLE;
         end
         HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: fetch/timeout counters, instruction and result latches,
   // program counter and retirement counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt   <= '0;
         tmo_cnt     <= '0;
         core_instr  <= '0;
         last_result <= '0;
         pc          <= '0;
         retired     <= '0;
         fault       <= 1'b0;
      end else begin
         if (state == FETCH && !fetch_last) fetch_cnt <= fetch_cnt + FL_W'(1);
         else                               fetch_cnt <= '0;

         if (state == FETCH && fetch_last) core_instr <= imem_data;

         // Counts EXEC cycles already spent; cleared whenever outside EXEC.
         if (state == EXEC) tmo_cnt <= tmo_cnt + TO_W'(1);
         else               tmo_cnt <= '0;

         if (state == EXEC && core_done) last_result <= core_result;

         if (state == EXEC && !core_done && exec_expire) fault <= 1'b1;

         if (state == UPDATE) begin
            pc <= br_taken ? br_target : pc + ADDR_W'(1);
            if (retired != '1) retired <= retired + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bitty_seq_ctrl.sv
// Self-checking bench for bitty_seq_ctrl: directed scenarios plus a random
// program run, checked against an instruction-level reference model.

module tb_bitty_seq_ctrl;

   localparam int ADDR_W = 8;
   localparam int INSTR_W = 16;
   localparam int DATA_W = 16;
   localparam int CNT_W = 16;

   logic               clk;
   logic               reset;
   logic               run;
   logic               step_mode;
   logic               step;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] core_instr;
   logic               core_start;
   logic               core_done;
   logic [DATA_W-1:0]  core_result;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               halted;
   logic               fault;
   logic [CNT_W-1:0]   retired;

   logic [INSTR_W-1:0] mem [0:255];

   int n_vec = 0;
   int n_err = 0;

   // core responder controls
   int          core_lat;
   bit          rand_lat;
   bit          withhold;
   bit          inject;
   logic [15:0] inject_res;
   logic [15:0] next_res;
   logic [15:0] res_given;

   bitty_seq_ctrl dut (
      .clk(clk), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
      .imem_addr(imem_addr), .imem_data(imem_data), .core_instr(core_instr),
      .core_start(core_start), .core_done(core_done), .core_result(core_result),
      .pc(pc), .busy(busy), .halted(halted), .fault(fault), .retired(retired)
   );

   // single-cycle instruction memory
   assign imem_data = mem[imem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_default();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; step = 1'b0; step_mode = 1'b0;
      withhold = 1'b0; rand_lat = 1'b0; inject = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pc"}, 32'(pc), 32'd0);
      check({tag, "_addr"}, 32'(imem_addr), 32'd0);
      check({tag, "_instr"}, 32'(core_instr), 32'd0);
      check({tag, "_retired"}, 32'(retired), 32'd0);
      check({tag, "_start"}, 32'(core_start), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_fault"}, 32'(fault), 32'd0);
   endtask

   task automatic step_pulse();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin tick(); n++; end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_start(input string tag, input int budget);
      int n = 0;
      while (!core_start && n < budget) begin tick(); n++; end
      check(tag, 32'(core_start), 32'd1);
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int n = 0;
      while (!halted && n < budget) begin tick(); n++; end
      check(tag, 32'(halted), 32'd1);
   endtask

   // Execution-core stand-in: answers each core_start after core_lat cycles
   // (0 = same cycle) unless withheld; can also inject a stray done pulse.
   initial begin
      int cnt;
      bit pending;
      cnt = 0; pending = 1'b0;
      core_done = 1'b0; core_result = '0; res_given = '0;
      forever begin
         @(posedge clk);
         #2;
         core_done = 1'b0;
         if (reset) begin
            pending = 1'b0;
         end else begin
            if (core_start) begin
               pending = 1'b1;
               cnt = rand_lat ? int'($urandom_range(0, 3)) : core_lat;
            end
            if (inject) begin
               core_done = 1'b1;
               core_result = inject_res;
               inject = 1'b0;
            end else if (pending && !withhold) begin
               if (cnt == 0) begin
                  if (rand_lat) begin
                     case ($urandom_range(0, 3))
                        0: core_result = 16'h0000;
                        1: core_result = 16'hFFFF;
                        2: core_result = 16'h0001;
                        default: core_result = 16'($urandom);
                     endcase
                  end else begin
                     core_result = next_res;
                  end
                  core_done = 1'b1;
                  res_given = core_result;
                  pending = 1'b0;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Instruction-level reference model: tracks architectural pc, last result
   // and retire count; checks each retirement and halt against the DUT.
   initial begin
      logic [ADDR_W-1:0] pc_m;
      logic [ADDR_W-1:0] exp_pc;
      logic [15:0]       lr_m;
      logic [15:0]       ins;
      logic [CNT_W-1:0]  prev_ret;
      int                ret_m;
      int                starts;
      int                lr_s;
      bit                prev_halt;
      bit                taken;
      pc_m = '0; lr_m = '0; ret_m = 0; starts = 0; prev_ret = '0; prev_halt = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (reset) begin
            pc_m = '0; lr_m = '0; ret_m = 0; starts = 0; prev_ret = '0; prev_halt = 1'b0;
         end else begin
            ins = mem[pc_m];
            if (core_start) begin
               starts++;
               check("start_instr", 32'(core_instr), 32'(ins));
            end
            if (retired != prev_ret) begin
               if (ins[1:0] == 2'b10) begin
                  lr_s = int'($signed(lr_m));
                  case (ins[3:2])
                     2'b00: taken = (lr_s == 0);
                     2'b01: taken = (lr_s > 0);
                     2'b10: taken = (lr_s < 0);
                     default: taken = 1'b0;
                  endcase
                  exp_pc = taken ? ins[11:4] : pc_m + 8'd1;
                  check("branch_no_start", 32'(starts), 32'd0);
               end else begin
                  exp_pc = pc_m + 8'd1;
                  lr_m = res_given;
                  check("alu_one_start", 32'(starts), 32'd1);
               end
               ret_m++;
               check("retire_pc", 32'(pc), 32'(exp_pc));
               check("retire_cnt", 32'(retired), 32'(ret_m));
               pc_m = exp_pc;
               starts = 0;
               prev_ret = retired;
            end
            if (halted && !prev_halt) begin
               check("halt_fault", 32'(fault), 32'(ins != 16'hFFFF));
               check("halt_pc", 32'(pc), 32'(pc_m));
               check("halt_retired", 32'(retired), 32'(ret_m));
               prev_halt = 1'b1;
            end
         end
      end
   end

   initial begin
      logic [31:0] r;
      logic [15:0] w;
      reset = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
      core_lat = 3; rand_lat = 1'b0; withhold = 1'b0; inject = 1'b0;
      inject_res = '0; next_res = '0;
      fill_default();

      // reset state
      do_reset();
      check_reset_vals("rst");

      // free-run ALU op then taken branch (cond 00, last_result 0) to a halt
      mem[8'h00] = 16'h0011;
      mem[8'h01] = 16'h0202;
      mem[8'h20] = 16'hFFFF;
      next_res = 16'h0000;
      core_lat = 3;
      run = 1'b1;
      tick(); check("c1_start", 32'(core_start), 32'd0);
      tick(); check("c2_start", 32'(core_start), 32'd0);
      tick(); check("c3_start", 32'(core_start), 32'd1);
      tick(); check("c4_start", 32'(core_start), 32'd0);
      repeat (4) tick();
      check("c8_pc", 32'(pc), 32'd1);
      check("c8_retired", 32'(retired), 32'd1);
      wait_halt("halt_wait1", 50);
      check("br00_pc", 32'(pc), 32'h20);
      check("halt_instr_fault", 32'(fault), 32'd0);
      check("halt_instr_retired", 32'(retired), 32'd2);

      // cond 01 with last_result 0xFFFF is not taken
      do_reset();
      fill_default();
      mem[8'h00] = 16'h0011;
      mem[8'h01] = 16'h0206;
      mem[8'h02] = 16'hFFFF;
      next_res = 16'hFFFF;
      run = 1'b1;
      wait_halt("halt_wait2", 60);
      check("br01_pc", 32'(pc), 32'd2);
      check("br01_retired", 32'(retired), 32'd2);

      // pc wrap from 0xFF to 0x00 in single-step mode
      do_reset();
      fill_default();
      mem[8'h00] = 16'h0FF2;
      next_res = 16'h0000;
      step_mode = 1'b1;
      step_pulse(); wait_idle("wrap_idle1", 30);
      check("wrap_pc_ff", 32'(pc), 32'hFF);
      step_pulse(); wait_idle("wrap_idle2", 30);
      check("wrap_pc_00", 32'(pc), 32'h00);

      // three step pulses, one while busy: two retirements, back in IDLE
      do_reset();
      fill_default();
      step_mode = 1'b1;
      run = 1'b1;
      core_lat = 2;
      step_pulse();
      tick();
      step_pulse();
      wait_idle("step_idle1", 30);
      step_pulse();
      wait_idle("step_idle2", 30);
      repeat (10) tick();
      check("step_retired", 32'(retired), 32'd2);
      check("step_busy", 32'(busy), 32'd0);
      check("step_halted", 32'(halted), 32'd0);

      // run dropped mid-instruction completes it, then stops
      do_reset();
      fill_default();
      mem[8'h01] = 16'h0402;
      core_lat = 5;
      next_res = 16'h0000;
      run = 1'b1;
      wait_start("rundrop_start", 20);
      run = 1'b0;
      wait_idle("rundrop_idle", 40);
      check("rundrop_retired", 32'(retired), 32'd1);
      check("rundrop_pc", 32'(pc), 32'd1);

      // stray core_done while IDLE must not touch last_result
      inject_res = 16'h8000;
      inject = 1'b1;
      tick();
      tick();
      step_mode = 1'b1;
      step_pulse();
      wait_idle("stray_idle", 30);
      check("stray_pc", 32'(pc), 32'h40);

      // core never answers: HALT with fault after exactly TIMEOUT EXEC cycles
      do_reset();
      fill_default();
      withhold = 1'b1;
      run = 1'b1;
      wait_start("tmo_start", 20);
      repeat (254) tick();
      check("tmo_255_halted", 32'(halted), 32'd0);
      tick();
      check("tmo_256_halted", 32'(halted), 32'd1);
      check("tmo_fault", 32'(fault), 32'd1);
      step_mode = 1'b1;
      step_pulse();
      repeat (5) tick();
      check("tmo_stays_halted", 32'(halted), 32'd1);
      do_reset();
      check_reset_vals("tmo_rst");

      // reset during EXEC returns to IDLE with pc 0 on the next cycle
      fill_default();
      mem[8'h00] = 16'h0FF2;
      mem[8'hFF] = 16'h0001;
      withhold = 1'b1;
      run = 1'b1;
      wait_start("mid_start", 30);
      check("mid_pc_before", 32'(pc), 32'hFF);
      tick();
      reset = 1'b1;
      tick();
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_pc", 32'(pc), 32'd0);
      check("mid_start_low", 32'(core_start), 32'd0);
      run = 1'b0;
      reset = 1'b0;
      withhold = 1'b0;

      // random programs, latencies, results and mode changes
      do_reset();
      for (int i = 0; i < 256; i++) begin
         r = $urandom;
         w = r[15:0];
         if ($urandom_range(0, 2) == 2) begin
            w[1:0] = 2'b10;
         end else begin
            if (w[1:0] == 2'b10) w[1:0] = 2'b00;
            if (w == 16'hFFFF) w = 16'h0001;
         end
         mem[i] = w;
      end
      rand_lat = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
         run  = ($urandom_range(0, 7) != 0);
         step = ($urandom_range(0, 3) == 0);
         tick();
      end
      step = 1'b0;
      run = 1'b0;
      wait_idle("rand_idle", 40);
      check("rand_progress", 32'(retired > 16'd50), 32'd1);
      check("rand_no_halt", 32'(halted), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
